// File: rtl/pwm_pulse_decoder.sv
// Servo-style PWM receiver: measures high time and period at 1 us resolution,
// validates each frame, classifies rotation and flags loss of signal.
module pwm_pulse_decoder #(
  parameter int unsigned CLK_FREQ_MHZ  = 100,
  parameter int unsigned MIN_PULSE_US  = 500,
  parameter int unsigned MAX_PULSE_US  = 2500,
  parameter int unsigned MIN_PERIOD_US = 5000,
  parameter int unsigned TIMEOUT_US    = 25000,
  parameter int unsigned DEADBAND_US   = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        pwm_in,
  output logic [11:0] pulse_us,
  output logic [15:0] period_us,
  output logic [1:0]  rotation,
  output logic        valid,
  output logic        frame_err,
  output logic        signal_lost
);

  localparam int unsigned PW = (CLK_FREQ_MHZ > 1) ? $clog2(CLK_FREQ_MHZ) : 1;
  localparam int unsigned IW = $clog2(TIMEOUT_US + 1);
  localparam logic [PW-1:0] PRESC_TC  = PW'(CLK_FREQ_MHZ - 1);
  localparam logic [IW-1:0] TIMEOUT   = IW'(TIMEOUT_US);
  localparam logic [11:0]   MIN_PULSE = 12'(MIN_PULSE_US);
  localparam logic [11:0]   MAX_PULSE = 12'(MAX_PULSE_US);
  localparam logic [15:0]   MIN_PER   = 16'(MIN_PERIOD_US);
  localparam logic [11:0]   FWD_TH    = 12'(1500 + DEADBAND_US);
  localparam logic [11:0]   REV_TH    = 12'(1500 - DEADBAND_US);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t        state, state_n;
  logic [2:0]    sync;
  logic [PW-1:0] presc, presc_n;
  logic [11:0]   hi_cnt, hi_n, hi_end, hi_lat, hi_lat_n, pulse_n;
  logic [15:0]   per_cnt, per_n, per_end, period_n;
  logic [IW-1:0] idle_cnt, idle_n;
  logic [1:0]    rot_n;
  logic          valid_n, err_n, lost_n;
  logic          rise, fall, any_edge, tick, timeout, accept;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync <= '0;
    else       sync <= {sync[1:0], pwm_in};
  end

  assign rise     = sync[1] & ~sync[2];
  assign fall     = ~sync[1] & sync[2];
  assign any_edge = rise | fall;
  assign tick     = (presc == PRESC_TC);
  assign timeout  = (idle_cnt >= TIMEOUT) && !any_edge;

  // Include the tick of the closing cycle so captured values are exact.
  assign hi_end  = (tick && hi_cnt  != '1) ? hi_cnt  + 12'd1 : hi_cnt;
  assign per_end = (tick && per_cnt != '1) ? per_cnt + 16'd1 : per_cnt;
  assign accept  = (hi_lat >= MIN_PULSE) && (hi_lat <= MAX_PULSE) && (per_end >= MIN_PER);

  always_comb begin
    state_n  = state;
    presc_n  = tick ? '0 : presc + 1'b1;
    hi_n     = hi_cnt;
    per_n    = per_cnt;
    idle_n   = any_edge ? '0 : ((tick && idle_cnt != '1) ? idle_cnt + 1'b1 : idle_cnt);
    hi_lat_n = hi_lat;
    pulse_n  = pulse_us;
    period_n = period_us;
    rot_n    = rotation;
    valid_n  = 1'b0;
    err_n    = 1'b0;
    lost_n   = any_edge ? 1'b0 : signal_lost;
    if (rise) presc_n = '0;

    case (state)
      IDLE: begin
        hi_n  = '0;
        per_n = '0;
        if (rise) state_n = HIGH;
      end
      HIGH: begin
        hi_n  = hi_end;
        per_n = per_end;
        if (fall) begin
          state_n  = LOW;
          hi_lat_n = hi_end;
        end
      end
      LOW: begin
        per_n = per_end;
        if (rise) begin
          state_n = HIGH;
          hi_n    = '0;
          per_n   = '0;
          if (accept) begin
            pulse_n  = hi_lat;
            period_n = per_end;
            rot_n    = (hi_lat > FWD_TH) ? 2'b01 : ((hi_lat < REV_TH) ? 2'b10 : 2'b00);
            valid_n  = 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (timeout) begin
      state_n = IDLE;
      lost_n  = 1'b1;
      rot_n   = 2'b00;
    end

    // Disabled: park in IDLE with counters cleared; reported values hold.
    if (!enable) begin
      state_n  = IDLE;
      presc_n  = '0;
      hi_n     = '0;
      per_n    = '0;
      idle_n   = '0;
      hi_lat_n = hi_lat;
      pulse_n  = pulse_us;
      period_n = period_us;
      rot_n    = rotation;
      valid_n  = 1'b0;
      err_n    = 1'b0;
      lost_n   = signal_lost;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      presc       <= '0;
      hi_cnt      <= '0;
      per_cnt     <= '0;
      idle_cnt    <= '0;
      hi_lat      <= '0;
      pulse_us    <= '0;
      period_us   <= '0;
      rotation    <= '0;
      valid       <= 1'b0;
      frame_err   <= 1'b0;
      signal_lost <= 1'b0;
    end else begin
      state       <= state_n;
      presc       <= presc_n;
      hi_cnt      <= hi_n;
      per_cnt     <= per_n;
      idle_cnt    <= idle_n;
      hi_lat      <= hi_lat_n;
      pulse_us    <= pulse_n;
      period_us   <= period_n;
      rotation    <= rot_n;
      valid       <= valid_n;
      frame_err   <= err_n;
      signal_lost <= lost_n;
    end
  end

endmodule

// File: tb/tb_pwm_pulse_decoder.sv
// Scoreboard bench for pwm_pulse_decoder: each completed frame queues its expected
// verdict, popped when valid or frame_err fires.
`timescale 1ns/1ns
module tb_pwm_pulse_decoder;

  logic        clk = 1'b0;
  logic        reset, enable, pwm_in;
  logic [11:0] pulse_us;
  logic [15:0] period_us;
  logic [1:0]  rotation;
  logic        valid, frame_err, signal_lost;

  // 2 MHz clock keeps real-microsecond frames short in cycles.
  pwm_pulse_decoder #(
    .CLK_FREQ_MHZ (2),
    .MIN_PERIOD_US(1200),
    .TIMEOUT_US   (3000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .pwm_in     (pwm_in),
    .pulse_us   (pulse_us),
    .period_us  (period_us),
    .rotation   (rotation),
    .valid      (valid),
    .frame_err  (frame_err),
    .signal_lost(signal_lost)
  );

  always #250 clk = ~clk;

  typedef struct {
    bit acc;
    int hi;
    int per;
    int rot;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_valid  = 0;
  int   last_pulse = 0, last_period = 0, last_rot = 0;

  task automatic check(input string tag, input int obs, input int exp, input int tol = 0);
    n_checks++;
    if (obs > exp + tol || obs < exp - tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  task automatic wait_us(input int n);
    repeat (2 * n) @(negedge clk);
  endtask

  task automatic push_frame(input int hi, input int lo);
    exp_t e;
    e.hi  = hi;
    e.per = hi + lo;
    e.acc = (hi >= 500) && (hi <= 2500) && (hi + lo >= 1200);
    e.rot = (hi > 1520) ? 1 : ((hi < 1480) ? 2 : 0);
    sb.push_back(e);
  endtask

  task automatic frame(input int hi, input int lo, input bit push);
    pwm_in = 1'b1;
    wait_us(hi);
    pwm_in = 1'b0;
    wait_us(lo);
    if (push) push_frame(hi, lo);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && (valid || frame_err)) begin
      if (valid) n_valid++;
      if (sb.size() == 0) begin
        check(valid ? "unexp_valid" : "unexp_frame_err", 1, 0);
      end else begin
        e = sb.pop_front();
        check("strobe_kind", int'(valid), int'(e.acc));
        check("both_strobes", int'(valid & frame_err), 0);
        if (e.acc) begin
          check("pulse_us", pulse_us, e.hi, 1);
          check("period_us", period_us, e.per, 1);
          check("rotation", rotation, e.rot);
          last_pulse  = e.hi;
          last_period = e.per;
          last_rot    = e.rot;
        end else begin
          check("rej_pulse_held", pulse_us, last_pulse, 1);
          check("rej_rot_held", rotation, last_rot);
        end
      end
    end
  end

  int hi_a[9] = '{1500, 1500, 1500, 1521, 1479, 2000, 1000, 300, 2600};
  int lo_a[9] = '{ 200,  200,  200,  200,  300,  200,  200, 900,  200};

  initial begin
    reset  = 1'b1;
    enable = 1'b1;
    pwm_in = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_pulse", pulse_us, 0);
    check("rst_period", period_us, 0);
    check("rst_rot", rotation, 0);
    check("rst_valid", valid, 0);
    check("rst_err", frame_err, 0);
    check("rst_lost", signal_lost, 0);
    reset = 1'b0;
    wait_us(100);

    // Steady stream: stop-band, thresholds, forward/reverse, rejects.
    for (int i = 0; i < 9; i++) frame(hi_a[i], lo_a[i], 1'b1);

    // Loss of signal: one more pulse then silence.
    pwm_in = 1'b1;
    wait_us(1200);
    pwm_in = 1'b0;
    check("valid_count_a", n_valid, 7);
    check("sb_empty_a", sb.size(), 0);
    wait_us(2990);
    check("lost_early", signal_lost, 0);
    for (int i = 0; i < 80; i++) begin
      if (signal_lost) break;
      @(negedge clk);
    end
    check("lost", signal_lost, 1);
    check("lost_rot", rotation, 0);
    last_rot = 0;
    check("lost_pulse_held", pulse_us, last_pulse, 1);
    check("lost_period_held", period_us, last_period, 1);
    wait_us(460);

    // Resume: loss clears on first edge; that edge is not evaluated.
    pwm_in = 1'b1;
    repeat (8) @(negedge clk);
    check("lost_clear", signal_lost, 0);
    repeat (2 * 1500 - 8) @(negedge clk);
    pwm_in = 1'b0;
    wait_us(200);
    push_frame(1500, 200);
    frame(2000, 200, 1'b1);

    // Disable mid-pulse, keep the pin toggling, then re-enable.
    pwm_in = 1'b1;
    wait_us(400);
    enable = 1'b0;
    wait_us(1100);
    pwm_in = 1'b0;
    wait_us(200);
    frame(1000, 200, 1'b0);
    frame(1000, 200, 1'b0);
    check("dis_pulse_held", pulse_us, last_pulse, 1);
    check("dis_period_held", period_us, last_period, 1);
    check("dis_rot_held", rotation, last_rot);
    check("dis_lost", signal_lost, 0);
    check("sb_empty_b", sb.size(), 0);
    enable = 1'b1;
    wait_us(100);
    frame(1000, 200, 1'b1);

    // Reset 800 us into a pulse: everything clears at once.
    pwm_in = 1'b1;
    wait_us(800);
    reset = 1'b1;
    #1;
    check("mid_rst_pulse", pulse_us, 0);
    check("mid_rst_period", period_us, 0);
    check("mid_rst_rot", rotation, 0);
    check("mid_rst_lost", signal_lost, 0);
    last_pulse  = 0;
    last_period = 0;
    last_rot    = 0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    wait_us(700);
    pwm_in = 1'b0;
    wait_us(300);
    check("post_rst_pulse", pulse_us, 0);
    check("valid_count_end", n_valid, 10);
    check("sb_empty_end", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
